hpdcache_mem_resp_read_upsizer: RTL

Sits between a narrow memory read-response channel and the cache's wide read-response port (mem_resp_read_valid_i/ready_o/resp). Collects consecutive narrow beats of one transaction ID into one wide word, LSB lane first. It then presents that word downstream with the accumulated error, the ID and the last flag. Throughput and buffering depth are fixed at compile time.

---
 rtl/hpdcache_pkg.sv | 31 +++
 rtl/hpdcache_rrsp_upsizer_buf.sv | 104 ++++++++++
 rtl/hpdcache_mem_resp_read_upsizer.sv | 112 +++++++++++
 3 files changed

// File: rtl/hpdcache_pkg.sv
// Shared helpers for the HPDcache memory read-response upsizer: width ratio,
// lane-counter sizing, power-of-two test and the per-buffer state encoding.
package hpdcache_pkg;

    typedef enum logic {
        BUF_FILL = 1'b0,
        BUF_FULL = 1'b1
    } upsizer_buf_state_e;

    function automatic int unsigned upsizer_ratio(input int unsigned narrow_w,
                                                  input int unsigned wide_w);
        return wide_w / narrow_w;
    endfunction

    // A single-lane configuration still keeps a one-bit counter.
    function automatic int unsigned upsizer_cnt_width(input int unsigned narrow_w,
                                                      input int unsigned wide_w);
        int unsigned r;
        r = upsizer_ratio(narrow_w, wide_w);
        if (r > 32'd1) begin
            return unsigned'($clog2(r));
        end else begin
            return 32'd1;
        end
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/hpdcache_rrsp_upsizer_buf.sv
// One wide assembly buffer: lane write, FILL/FULL state, and capture of the
// group's first ID, OR-ed error and closing last flag.
module hpdcache_rrsp_upsizer_buf
    import hpdcache_pkg::*;
#(
    parameter int unsigned NarrowWidth = 128,
    parameter int unsigned WideWidth   = 512,
    parameter int unsigned IdWidth     = 7,
    parameter int unsigned CntWidth    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_i,
    input  logic [CntWidth-1:0]    lane_i,
    input  logic                   close_i,
    input  logic [NarrowWidth-1:0] data_i,
    input  logic [IdWidth-1:0]     id_i,
    input  logic                   error_i,
    input  logic                   last_i,
    input  logic                   rd_i,
    output logic                   full_o,
    output logic [WideWidth-1:0]   data_o,
    output logic [IdWidth-1:0]     id_o,
    output logic                   error_o,
    output logic                   last_o
);
    localparam int unsigned Ratio = WideWidth / NarrowWidth;

    upsizer_buf_state_e   r_state;
    upsizer_buf_state_e   w_state_next;
    logic [WideWidth-1:0] r_data;
    logic [WideWidth-1:0] w_data_base;
    logic [WideWidth-1:0] w_data_next;
    logic [IdWidth-1:0]   r_id;
    logic                 r_error;
    logic                 r_last;
    logic                 w_first;

    assign w_first = (lane_i == {CntWidth{1'b0}});

    // FILL/FULL next-state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BUF_FILL: begin
                if (wr_i && close_i) begin
                    w_state_next = BUF_FULL;
                end else begin
                    w_state_next = BUF_FILL;
                end
            end
            BUF_FULL: begin
                if (rd_i) begin
                    w_state_next = BUF_FILL;
                end else begin
                    w_state_next = BUF_FULL;
                end
            end
            default: w_state_next = BUF_FILL;
        endcase
    end

    // Lane write; the first beat of a group zeroes the other lanes so an
    // early-closed word never carries stale data.
    always_comb begin
        w_data_base = w_first ? {WideWidth{1'b0}} : r_data;
        w_data_next = r_data;
        if (wr_i) begin
            for (int unsigned l = 0; l < Ratio; l++) begin
                w_data_next[l*NarrowWidth +: NarrowWidth] =
                    (lane_i == CntWidth'(l)) ? data_i
                                             : w_data_base[l*NarrowWidth +: NarrowWidth];
            end
        end else begin
            w_data_next = r_data;
        end
    end

    // Buffer state and captured group fields
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= BUF_FILL;
            r_data  <= {WideWidth{1'b0}};
            r_id    <= {IdWidth{1'b0}};
            r_error <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_data  <= w_data_next;
            if (wr_i) begin
                r_id    <= w_first ? id_i : r_id;
                r_error <= (w_first ? 1'b0 : r_error) | error_i;
                r_last  <= last_i;
            end
        end
    end

    assign full_o  = (r_state == BUF_FULL);
    assign data_o  = r_data;
    assign id_o    = r_id;
    assign error_o = r_error;
    assign last_o  = r_last;

endmodule

// File: rtl/hpdcache_mem_resp_read_upsizer.sv
// Packs narrow memory read-response beats into wide cache words, LSB lane first.
// Define HPDCACHE_RRSP_UPSIZER_PIPE_EN for two ping-pong buffers (R cycles/word).
module hpdcache_mem_resp_read_upsizer
    import hpdcache_pkg::*;
#(
    parameter int unsigned NarrowWidth = 128,
    parameter int unsigned WideWidth   = 512,
    parameter int unsigned IdWidth     = 7
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [NarrowWidth-1:0] in_data_i,
    input  logic [IdWidth-1:0]     in_id_i,
    input  logic                   in_error_i,
    input  logic                   in_last_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [WideWidth-1:0]   out_data_o,
    output logic [IdWidth-1:0]     out_id_o,
    output logic                   out_error_o,
    output logic                   out_last_o,
    output logic                   id_mismatch_o
);
    localparam int unsigned Ratio    = upsizer_ratio(NarrowWidth, WideWidth);
    localparam int unsigned CntWidth = upsizer_cnt_width(NarrowWidth, WideWidth);
`ifdef HPDCACHE_RRSP_UPSIZER_PIPE_EN
    localparam int unsigned NumBuf = 2;
`else
    localparam int unsigned NumBuf = 1;
`endif
    localparam bit                  PipeEn   = (NumBuf == 2);
    localparam logic [CntWidth-1:0] LastLane = CntWidth'(Ratio - 32'd1);

    if (!is_pow2(NarrowWidth) || !is_pow2(WideWidth) || (NarrowWidth > WideWidth)) begin : g_bad_cfg
        $error("upsizer widths must be powers of two with NarrowWidth <= WideWidth");
    end

    logic [CntWidth-1:0]  r_cnt;
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic                 r_id_mismatch;
    logic                 w_beat_hs;
    logic                 w_word_hs;
    logic                 w_close;
    logic [NumBuf-1:0]    w_buf_full;
    logic [NumBuf-1:0]    w_buf_err;
    logic [NumBuf-1:0]    w_buf_last;
    logic [WideWidth-1:0] w_buf_data [NumBuf];
    logic [IdWidth-1:0]   w_buf_id   [NumBuf];

    assign in_ready_o  = ~w_buf_full[r_wr_ptr];
    assign out_valid_o = w_buf_full[r_rd_ptr];
    assign w_beat_hs   = in_valid_i & in_ready_o;
    assign w_word_hs   = out_valid_o & out_ready_i;
    assign w_close     = (r_cnt == LastLane) | in_last_i;

    for (genvar b = 0; b < int'(NumBuf); b++) begin : g_buf
        hpdcache_rrsp_upsizer_buf #(
            .NarrowWidth (NarrowWidth),
            .WideWidth   (WideWidth),
            .IdWidth     (IdWidth),
            .CntWidth    (CntWidth)
        ) u_buf (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .wr_i    (w_beat_hs && (r_wr_ptr == 1'(b))),
            .lane_i  (r_cnt),
            .close_i (w_close),
            .data_i  (in_data_i),
            .id_i    (in_id_i),
            .error_i (in_error_i),
            .last_i  (in_last_i),
            .rd_i    (w_word_hs && (r_rd_ptr == 1'(b))),
            .full_o  (w_buf_full[b]),
            .data_o  (w_buf_data[b]),
            .id_o    (w_buf_id[b]),
            .error_o (w_buf_err[b]),
            .last_o  (w_buf_last[b])
        );
    end

    // Lane counter, ping-pong pointers and ID-change flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt         <= {CntWidth{1'b0}};
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_id_mismatch <= 1'b0;
        end else begin
            if (w_beat_hs) begin
                r_cnt <= w_close ? {CntWidth{1'b0}} : (r_cnt + CntWidth'(1));
            end
            if (w_beat_hs && w_close) begin
                r_wr_ptr <= PipeEn ? ~r_wr_ptr : 1'b0;
            end
            if (w_word_hs) begin
                r_rd_ptr <= PipeEn ? ~r_rd_ptr : 1'b0;
            end
            r_id_mismatch <= w_beat_hs && (r_cnt != {CntWidth{1'b0}})
                             && (in_id_i != w_buf_id[r_wr_ptr]);
        end
    end

    assign out_data_o    = out_valid_o ? w_buf_data[r_rd_ptr] : {WideWidth{1'b0}};
    assign out_id_o      = out_valid_o ? w_buf_id[r_rd_ptr]   : {IdWidth{1'b0}};
    assign out_error_o   = out_valid_o & w_buf_err[r_rd_ptr];
    assign out_last_o    = out_valid_o & w_buf_last[r_rd_ptr];
    assign id_mismatch_o = r_id_mismatch;

endmodule
